// File: rtl/morse_tx_sequencer.sv
// Morse transmit sequencer: queues {len, pattern} characters and serialises them onto Y at tick rate.
// Optional feature MORSE_TX_ABORT_EN adds an abort input that flushes the queue and ends the run.
module morse_tx_sequencer #(
  parameter int DEPTH     = 16,
  parameter int GAP_UNITS = 3,
  parameter int PAT_W     = 22
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [PAT_W+4:0] wr_data,
  input  logic             Start,
  input  logic             tick,
`ifdef MORSE_TX_ABORT_EN
  input  logic             abort,
`endif
  output logic             Y,
  output logic             busy,
  output logic             done,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int DW = PAT_W + 5;
  localparam logic [2:0]    GAP_INIT = 3'(GAP_UNITS);
  localparam logic [4:0]    PAT_LEN  = 5'(PAT_W);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, DONE} state_t;

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             push, pop, flush, kill;
  logic [DW-1:0]    head;
  logic [4:0]       head_len, len_c;

  state_t           state, state_nxt, exit_st;
  logic [PAT_W-1:0] sh, sh_nxt;
  logic [4:0]       bitcnt, bitcnt_nxt;
  logic [2:0]       gapcnt, gapcnt_nxt;
  logic             y_nxt;

`ifdef MORSE_TX_ABORT_EN
  assign flush = abort;
`else
  assign flush = 1'b0;
`endif

  // Abort wins over a same-cycle write; full is the registered flag, so a write racing a pop at full is dropped.
  assign push = wr_en && !full && !flush;
  assign kill = flush && (state != IDLE);

  assign head     = mem[rd_ptr];
  assign head_len = head[DW-1:PAT_W];
  assign len_c    = (head_len > PAT_LEN) ? PAT_LEN : head_len;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      sh     <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
      Y      <= 1'b0;
    end else begin
      state  <= state_nxt;
      sh     <= sh_nxt;
      bitcnt <= bitcnt_nxt;
      gapcnt <= gapcnt_nxt;
      Y      <= y_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sh_nxt     = sh;
    bitcnt_nxt = bitcnt;
    gapcnt_nxt = gapcnt;
    pop        = 1'b0;
    exit_st    = empty ? DONE : LOAD;

    case (state)
      IDLE: begin
        if (Start && !empty) state_nxt = LOAD;
      end
      LOAD: begin
        pop        = 1'b1;
        sh_nxt     = head[PAT_W-1:0] << (PAT_LEN - len_c);
        bitcnt_nxt = len_c;
        gapcnt_nxt = GAP_INIT;
        state_nxt  = (len_c == 5'd0) ? GAP : SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          sh_nxt     = sh << 1;
          bitcnt_nxt = bitcnt - 1'b1;
          if (bitcnt <= 5'd1) begin
            gapcnt_nxt = GAP_INIT;
            state_nxt  = (GAP_UNITS == 0) ? exit_st : GAP;
          end
        end
      end
      GAP: begin
        // A zero count only arises from an empty character with no gap configured.
        if (gapcnt == 3'd0) begin
          state_nxt = exit_st;
        end else if (tick) begin
          gapcnt_nxt = gapcnt - 1'b1;
          if (gapcnt == 3'd1) state_nxt = exit_st;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (kill) state_nxt = DONE;

    // Y is registered from the next state so the first bit appears the cycle after LOAD.
    y_nxt = (state_nxt == SHIFT) && sh_nxt[PAT_W-1];
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
